// File: rtl/mc_controller_ws.sv
// Multicycle MIPS control unit: wait-state aware sequencing, direct alu_op
// generation, sticky error trapping and cycle/instruction counters.
module mc_controller_ws #(
    parameter int unsigned CNT_W   = 32,
    parameter int unsigned TIMEOUT = 15,
    parameter int unsigned HAS_JAL = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             zero,
    input  logic [5:0]       opcode,
    input  logic [5:0]       func,
    input  logic             mem_ready,
    output logic             pc_write_en,
    output logic             ir_write,
    output logic             reg_dst,
    output logic             jal_reg,
    output logic             pc_to_reg,
    output logic             mem_to_reg,
    output logic             reg_write,
    output logic             alu_src_a,
    output logic             i_or_d,
    output logic             mem_write,
    output logic             mem_read,
    output logic [1:0]       alu_src_b,
    output logic [1:0]       pc_src,
    output logic [2:0]       alu_op,
    output logic [3:0]       state,
    output logic             illegal_op,
    output logic             bus_err,
    output logic [CNT_W-1:0] cycle_cnt,
    output logic [CNT_W-1:0] instr_cnt
);

    localparam int unsigned WAIT_W = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT + 1);

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_J     = 6'b000010;
    localparam logic [5:0] OP_JAL   = 6'b000011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_BNE   = 6'b000101;
    localparam logic [5:0] OP_ADDI  = 6'b001000;
    localparam logic [5:0] OP_SLTI  = 6'b001010;
    localparam logic [5:0] OP_ANDI  = 6'b001100;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;

    localparam logic [5:0] FN_JR    = 6'b001000;
    localparam logic [5:0] FN_ADD   = 6'b100000;
    localparam logic [5:0] FN_SUB   = 6'b100010;
    localparam logic [5:0] FN_AND   = 6'b100100;
    localparam logic [5:0] FN_OR    = 6'b100101;
    localparam logic [5:0] FN_SLT   = 6'b101010;

    localparam logic [2:0] ALU_AND  = 3'b000;
    localparam logic [2:0] ALU_OR   = 3'b001;
    localparam logic [2:0] ALU_ADD  = 3'b010;
    localparam logic [2:0] ALU_SUB  = 3'b110;
    localparam logic [2:0] ALU_SLT  = 3'b111;

    typedef enum logic [3:0] {
        S_IF       = 4'd0,
        S_ID       = 4'd1,
        S_BRANCH   = 4'd2,
        S_JUMP     = 4'd3,
        S_RTYPE_EX = 4'd4,
        S_RTYPE_WB = 4'd5,
        S_MEM_ADDR = 4'd6,
        S_LW_READ  = 4'd7,
        S_LW_WB    = 4'd8,
        S_SW_WRITE = 4'd9,
        S_JAL      = 4'd10,
        S_JR       = 4'd11,
        S_IMM_EX   = 4'd12,
        S_IMM_WB   = 4'd13,
        S_ERR      = 4'd15
    } state_t;

    state_t            cur_state;
    state_t            nxt_state;
    logic [WAIT_W-1:0] wait_cnt;
    logic              in_mem;
    logic              timeout_hit;
    logic              func_alu;

    assign state    = cur_state;
    assign in_mem   = (cur_state == S_IF) || (cur_state == S_LW_READ) ||
                      (cur_state == S_SW_WRITE);
    assign func_alu = (func == FN_ADD) || (func == FN_SUB) || (func == FN_AND) ||
                      (func == FN_OR)  || (func == FN_SLT);
    assign timeout_hit = (TIMEOUT != 0) && in_mem && !mem_ready &&
                         (wait_cnt == WAIT_W'(TIMEOUT));

    // State register, wait counter, sticky flags and performance counters
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cur_state  <= S_IF;
            wait_cnt   <= '0;
            illegal_op <= 1'b0;
            bus_err    <= 1'b0;
            cycle_cnt  <= '0;
            instr_cnt  <= '0;
        end else begin
            cur_state <= nxt_state;
            if (mem_ready || !in_mem)
                wait_cnt <= '0;
            else
                wait_cnt <= wait_cnt + WAIT_W'(1);
            if (cur_state == S_ID && nxt_state == S_ERR)
                illegal_op <= 1'b1;
            if (timeout_hit)
                bus_err <= 1'b1;
            if (cur_state != S_ERR)
                cycle_cnt <= cycle_cnt + CNT_W'(1);
            if (nxt_state == S_IF && cur_state != S_IF && cur_state != S_ERR)
                instr_cnt <= instr_cnt + CNT_W'(1);
        end
    end

    // Next-state sequencing, including memory stretch and timeout trap
    always_comb begin
        nxt_state = cur_state;
        case (cur_state)
            S_IF: begin
                if (timeout_hit)    nxt_state = S_ERR;
                else if (mem_ready) nxt_state = S_ID;
            end
            S_ID: begin
                case (opcode)
                    OP_BEQ, OP_BNE:            nxt_state = S_BRANCH;
                    OP_J:                      nxt_state = S_JUMP;
                    OP_JAL:                    nxt_state = (HAS_JAL != 0) ? S_JAL : S_ERR;
                    OP_RTYPE: begin
                        if (func == FN_JR)     nxt_state = S_JR;
                        else if (func_alu)     nxt_state = S_RTYPE_EX;
                        else                   nxt_state = S_ERR;
                    end
                    OP_LW, OP_SW:              nxt_state = S_MEM_ADDR;
                    OP_ADDI, OP_ANDI, OP_SLTI: nxt_state = S_IMM_EX;
                    default:                   nxt_state = S_ERR;
                endcase
            end
            S_MEM_ADDR: nxt_state = (opcode == OP_LW) ? S_LW_READ : S_SW_WRITE;
            S_LW_READ: begin
                if (timeout_hit)    nxt_state = S_ERR;
                else if (mem_ready) nxt_state = S_LW_WB;
            end
            S_SW_WRITE: begin
                if (timeout_hit)    nxt_state = S_ERR;
                else if (mem_ready) nxt_state = S_IF;
            end
            S_RTYPE_EX: nxt_state = S_RTYPE_WB;
            S_IMM_EX:   nxt_state = S_IMM_WB;
            S_BRANCH, S_JUMP, S_JAL, S_JR,
            S_RTYPE_WB, S_IMM_WB, S_LW_WB: nxt_state = S_IF;
            S_ERR:      nxt_state = S_ERR;
            default:    nxt_state = S_ERR;
        endcase
    end

    // Datapath control decode; ir_write/pc_write_en follow mem_ready and zero
    always_comb begin
        pc_write_en = 1'b0;
        ir_write    = 1'b0;
        reg_dst     = 1'b0;
        jal_reg     = 1'b0;
        pc_to_reg   = 1'b0;
        mem_to_reg  = 1'b0;
        reg_write   = 1'b0;
        alu_src_a   = 1'b0;
        i_or_d      = 1'b0;
        mem_write   = 1'b0;
        mem_read    = 1'b0;
        alu_src_b   = 2'b00;
        pc_src      = 2'b00;
        alu_op      = ALU_ADD;
        case (cur_state)
            S_IF: begin
                mem_read    = 1'b1;
                alu_src_b   = 2'b01;
                ir_write    = mem_ready;
                pc_write_en = mem_ready;
            end
            S_ID: alu_src_b = 2'b11;
            S_BRANCH: begin
                alu_src_a   = 1'b1;
                alu_op      = ALU_SUB;
                pc_src      = 2'b11;
                pc_write_en = (opcode == OP_BNE) ? ~zero : zero;
            end
            S_JUMP: begin
                pc_src      = 2'b01;
                pc_write_en = 1'b1;
            end
            S_JAL: begin
                reg_dst     = 1'b1;
                jal_reg     = 1'b1;
                pc_to_reg   = 1'b1;
                reg_write   = 1'b1;
                pc_src      = 2'b01;
                pc_write_en = 1'b1;
            end
            S_JR: begin
                pc_src      = 2'b10;
                pc_write_en = 1'b1;
            end
            S_RTYPE_EX: begin
                alu_src_a = 1'b1;
                case (func)
                    FN_SUB:  alu_op = ALU_SUB;
                    FN_AND:  alu_op = ALU_AND;
                    FN_OR:   alu_op = ALU_OR;
                    FN_SLT:  alu_op = ALU_SLT;
                    default: alu_op = ALU_ADD;
                endcase
            end
            S_RTYPE_WB: begin
                reg_dst   = 1'b1;
                reg_write = 1'b1;
            end
            S_IMM_EX: begin
                alu_src_a = 1'b1;
                alu_src_b = 2'b10;
                case (opcode)
                    OP_ANDI: alu_op = ALU_AND;
                    OP_SLTI: alu_op = ALU_SLT;
                    default: alu_op = ALU_ADD;
                endcase
            end
            S_IMM_WB: reg_write = 1'b1;
            S_MEM_ADDR: begin
                alu_src_a = 1'b1;
                alu_src_b = 2'b10;
            end
            S_LW_READ: begin
                mem_read = 1'b1;
                i_or_d   = 1'b1;
            end
            S_LW_WB: begin
                mem_to_reg = 1'b1;
                reg_write  = 1'b1;
            end
            S_SW_WRITE: begin
                mem_write = 1'b1;
                i_or_d    = 1'b1;
            end
            default: ;
        endcase
    end

endmodule

// File: tb/tb_mc_controller_ws.sv
// Randomized instruction-level bench: the driver expands each instruction
// into its expected per-cycle behaviour and queues it; a negedge monitor
// pops one expectation per cycle and compares it with the controller.
module tb_mc_controller_ws;

    localparam int TIMEOUT = 15;

    localparam logic [3:0] IF_ = 4'd0, ID_ = 4'd1, BR_ = 4'd2, JMP_ = 4'd3,
        REX_ = 4'd4, RWB_ = 4'd5, MAD_ = 4'd6, LWR_ = 4'd7, LWB_ = 4'd8,
        SWW_ = 4'd9, JAL_ = 4'd10, JR_ = 4'd11, IEX_ = 4'd12, IWB_ = 4'd13,
        ERR_ = 4'd15;

    typedef struct {
        logic [3:0]  st;
        logic        mr, mw, rw, pcw, irw, iod, m2r, rdst, jreg, p2r, asa;
        logic [1:0]  bsrc, psrc;
        logic [2:0]  aop;
        logic        ill, berr;
        logic [31:0] cyc, ins;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst, zero, mem_ready;
    logic [5:0]  opcode, func;
    logic        pc_write_en, ir_write, reg_dst, jal_reg, pc_to_reg, mem_to_reg;
    logic        reg_write, alu_src_a, i_or_d, mem_write, mem_read;
    logic [1:0]  alu_src_b, pc_src;
    logic [2:0]  alu_op;
    logic [3:0]  state;
    logic        illegal_op, bus_err;
    logic [31:0] cycle_cnt, instr_cnt;

    logic        n_pc_write_en, n_ir_write, n_reg_dst, n_jal_reg, n_pc_to_reg;
    logic        n_mem_to_reg, n_reg_write, n_alu_src_a, n_i_or_d, n_mem_write;
    logic        n_mem_read, n_illegal_op, n_bus_err;
    logic [1:0]  n_alu_src_b, n_pc_src;
    logic [2:0]  n_alu_op;
    logic [3:0]  n_state;
    logic [31:0] n_cycle_cnt, n_instr_cnt;

    exp_t q[$];
    int   checks = 0;
    int   failures = 0;
    int   m_cyc = 0, m_instr = 0;
    bit   m_ill = 0, m_berr = 0;

    always #5 clk = ~clk;

    mc_controller_ws #(.CNT_W(32), .TIMEOUT(TIMEOUT), .HAS_JAL(1)) dut (
        .clk(clk), .rst(rst), .zero(zero), .opcode(opcode), .func(func),
        .mem_ready(mem_ready), .pc_write_en(pc_write_en), .ir_write(ir_write),
        .reg_dst(reg_dst), .jal_reg(jal_reg), .pc_to_reg(pc_to_reg),
        .mem_to_reg(mem_to_reg), .reg_write(reg_write), .alu_src_a(alu_src_a),
        .i_or_d(i_or_d), .mem_write(mem_write), .mem_read(mem_read),
        .alu_src_b(alu_src_b), .pc_src(pc_src), .alu_op(alu_op), .state(state),
        .illegal_op(illegal_op), .bus_err(bus_err), .cycle_cnt(cycle_cnt),
        .instr_cnt(instr_cnt));

    mc_controller_ws #(.CNT_W(32), .TIMEOUT(TIMEOUT), .HAS_JAL(0)) dut_nj (
        .clk(clk), .rst(rst), .zero(zero), .opcode(opcode), .func(func),
        .mem_ready(mem_ready), .pc_write_en(n_pc_write_en), .ir_write(n_ir_write),
        .reg_dst(n_reg_dst), .jal_reg(n_jal_reg), .pc_to_reg(n_pc_to_reg),
        .mem_to_reg(n_mem_to_reg), .reg_write(n_reg_write), .alu_src_a(n_alu_src_a),
        .i_or_d(n_i_or_d), .mem_write(n_mem_write), .mem_read(n_mem_read),
        .alu_src_b(n_alu_src_b), .pc_src(n_pc_src), .alu_op(n_alu_op), .state(n_state),
        .illegal_op(n_illegal_op), .bus_err(n_bus_err), .cycle_cnt(n_cycle_cnt),
        .instr_cnt(n_instr_cnt));

    // Expected controls for a state; Mealy and func-dependent fields are set by callers
    function automatic exp_t base(input logic [3:0] st);
        exp_t e;
        e = '{default: '0};
        e.st  = st;
        e.aop = 3'b010;
        case (st)
            IF_:  begin e.mr = 1; e.bsrc = 2'b01; end
            ID_:  e.bsrc = 2'b11;
            BR_:  begin e.asa = 1; e.aop = 3'b110; e.psrc = 2'b11; end
            JMP_: begin e.psrc = 2'b01; e.pcw = 1; end
            JAL_: begin e.rdst = 1; e.jreg = 1; e.p2r = 1; e.rw = 1; e.psrc = 2'b01; e.pcw = 1; end
            JR_:  begin e.psrc = 2'b10; e.pcw = 1; end
            REX_: e.asa = 1;
            RWB_: begin e.rdst = 1; e.rw = 1; end
            IEX_: begin e.asa = 1; e.bsrc = 2'b10; end
            IWB_: e.rw = 1;
            MAD_: begin e.asa = 1; e.bsrc = 2'b10; end
            LWR_: begin e.mr = 1; e.iod = 1; end
            LWB_: begin e.m2r = 1; e.rw = 1; end
            SWW_: begin e.mw = 1; e.iod = 1; end
            default: ;
        endcase
        return e;
    endfunction

    function automatic logic [21:0] pack_exp(input exp_t e);
        return {e.st, e.mr, e.mw, e.rw, e.pcw, e.irw, e.iod, e.m2r, e.rdst,
                e.jreg, e.p2r, e.asa, e.bsrc, e.psrc, e.aop};
    endfunction

    // Drive one cycle of inputs and queue what the controller must show in it
    task automatic step(input exp_t e, input bit rdy, input bit z, input bit rstv);
        mem_ready = rdy;
        zero      = z;
        rst       = rstv;
        if (!rstv) begin
            m_cyc = 0; m_instr = 0; m_ill = 0; m_berr = 0;
        end
        e.cyc  = 32'(m_cyc);
        e.ins  = 32'(m_instr);
        e.ill  = m_ill;
        e.berr = m_berr;
        q.push_back(e);
        @(posedge clk);
        #1;
        if (rstv && e.st != ERR_) m_cyc++;
    endtask

    task automatic do_reset(input bit rdy);
        exp_t e;
        e = base(IF_);
        e.pcw = rdy;
        e.irw = rdy;
        step(e, rdy, 1'($urandom), 1'b0);
    endtask

    // Memory state held for w not-ready cycles; err reports a timeout trap
    task automatic mem_phase(input logic [3:0] st, input int w, output bit err);
        exp_t e;
        err = 0;
        for (int i = 0; i < w; i++) begin
            step(base(st), 1'b0, 1'($urandom), 1'b1);
            if (TIMEOUT != 0 && i == TIMEOUT) begin
                m_berr = 1;
                err = 1;
                return;
            end
        end
        e = base(st);
        if (st == IF_) begin e.pcw = 1; e.irw = 1; end
        step(e, 1'b1, 1'($urandom), 1'b1);
    endtask

    task automatic err_tail(input int n);
        for (int i = 0; i < n; i++)
            step(base(ERR_), 1'($urandom), 1'($urandom), 1'b1);
    endtask

    task automatic any_step(input logic [3:0] st);
        step(base(st), 1'($urandom), 1'($urandom), 1'b1);
    endtask

    // Kinds: 0 add 1 sub 2 and 3 or 4 slt 5 jr 6 lw 7 sw 8 beq 9 bne
    // 10 j 11 jal 12 addi 13 andi 14 slti 15 illegal opcode 111111
    task automatic run_instr(input int kind, input int w_if, input int w_mem, input bit z);
        exp_t e;
        bit   err;
        logic [5:0] fns [5] = '{6'b100000, 6'b100010, 6'b100100, 6'b100101, 6'b101010};
        logic [2:0] ops [5] = '{3'b010, 3'b110, 3'b000, 3'b001, 3'b111};
        logic [5:0] iop [3] = '{6'b001000, 6'b001100, 6'b001010};
        func = 6'($urandom);
        case (kind)
            0, 1, 2, 3, 4: begin opcode = 6'b000000; func = fns[kind]; end
            5:  begin opcode = 6'b000000; func = 6'b001000; end
            6:  opcode = 6'b100011;
            7:  opcode = 6'b101011;
            8:  opcode = 6'b000100;
            9:  opcode = 6'b000101;
            10: opcode = 6'b000010;
            11: opcode = 6'b000011;
            12, 13, 14: opcode = iop[kind - 12];
            default: opcode = 6'b111111;
        endcase
        mem_phase(IF_, w_if, err);
        if (err) begin err_tail(3); return; end
        any_step(ID_);
        case (kind)
            0, 1, 2, 3, 4: begin
                e = base(REX_); e.aop = ops[kind];
                step(e, 1'($urandom), 1'($urandom), 1'b1);
                any_step(RWB_);
            end
            5:  any_step(JR_);
            6, 7: begin
                any_step(MAD_);
                mem_phase((kind == 6) ? LWR_ : SWW_, w_mem, err);
                if (err) begin err_tail(3); return; end
                if (kind == 6) any_step(LWB_);
            end
            8, 9: begin
                e = base(BR_);
                e.pcw = (kind == 8) ? z : ~z;
                step(e, 1'($urandom), z, 1'b1);
            end
            10: any_step(JMP_);
            11: any_step(JAL_);
            12, 13, 14: begin
                e = base(IEX_); e.aop = ops[(kind == 12) ? 0 : (kind == 13) ? 2 : 4];
                step(e, 1'($urandom), 1'($urandom), 1'b1);
                any_step(IWB_);
            end
            default: begin
                m_ill = 1;
                err_tail(3);
                return;
            end
        endcase
        m_instr++;
    endtask

    // Monitor: one queued expectation per cycle, compared away from the clock edge
    always @(negedge clk) begin
        exp_t e;
        logic [21:0] got;
        if (q.size() > 0) begin
            e = q.pop_front();
            got = {state, mem_read, mem_write, reg_write, pc_write_en, ir_write,
                   i_or_d, mem_to_reg, reg_dst, jal_reg, pc_to_reg, alu_src_a,
                   alu_src_b, pc_src, alu_op};
            checks++;
            if (got !== pack_exp(e)) begin
                failures++;
                $display("FAIL ctl t=%0t got=%h exp=%h (state got %0d exp %0d)",
                         $time, got, pack_exp(e), state, e.st);
            end
            checks++;
            if ({illegal_op, bus_err, cycle_cnt, instr_cnt} !== {e.ill, e.berr, e.cyc, e.ins}) begin
                failures++;
                $display("FAIL cnt t=%0t got ill=%b berr=%b cyc=%0d ins=%0d exp ill=%b berr=%b cyc=%0d ins=%0d",
                         $time, illegal_op, bus_err, cycle_cnt, instr_cnt,
                         e.ill, e.berr, e.cyc, e.ins);
            end
        end
    end

    initial begin
        rst = 1'b0; zero = 1'b0; mem_ready = 1'b0; opcode = '0; func = '0;
        repeat (2) @(posedge clk);
        #1;
        do_reset(1'b1);

        // Directed walk-throughs of the main instruction classes
        run_instr(0, 0, 0, 0);
        run_instr(6, 0, 3, 0);
        run_instr(8, 0, 0, 1);
        run_instr(9, 0, 0, 1);
        run_instr(11, 1, 0, 0);
        run_instr(0, TIMEOUT, 0, 0);
        run_instr(7, 0, TIMEOUT, 0);

        for (int n = 0; n < 120; n++)
            run_instr($urandom_range(14, 0), $urandom_range(4, 0),
                      $urandom_range(4, 0), 1'($urandom));

        // Illegal opcode traps after ID and stays there
        run_instr(15, 0, 0, 0);
        do_reset(1'b0);

        // Reset in the middle of a stretched store
        opcode = 6'b101011;
        begin
            bit err;
            mem_phase(IF_, 0, err);
        end
        any_step(ID_);
        any_step(MAD_);
        step(base(SWW_), 1'b0, 1'b0, 1'b1);
        step(base(SWW_), 1'b0, 1'b0, 1'b1);
        do_reset(1'b0);

        // Fetch never completes: timeout trap after TIMEOUT+1 cycles
        run_instr(0, 100, 0, 0);
        do_reset(1'b1);

        // Load whose read times out
        run_instr(6, 0, 40, 0);
        do_reset(1'b1);

        // jal on the instance built without jal support
        opcode = 6'b000011;
        begin
            bit err;
            mem_phase(IF_, 0, err);
        end
        any_step(ID_);
        checks++;
        if (n_state !== ERR_ || n_illegal_op !== 1'b1) begin
            failures++;
            $display("FAIL nojal got state=%0d ill=%b exp state=15 ill=1", n_state, n_illegal_op);
        end
        any_step(JAL_);
        m_instr++;

        for (int n = 0; n < 20; n++)
            run_instr($urandom_range(14, 0), $urandom_range(3, 0),
                      $urandom_range(3, 0), 1'($urandom));

        @(negedge clk);
        #1;
        checks++;
        if (q.size() != 0) begin
            failures++;
            $display("FAIL drain got %0d pending exp 0", q.size());
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/mc_controller_ws.md
Name: mc_controller_ws

Overview:
- Next-generation multicycle MIPS control unit: wait-state aware, with performance counters and error trapping.
- Sequences IF/ID/EX/MEM/WB for R-type (add, sub, and, or, slt, jr), lw, sw, beq, bne, j, jal, addi, andi, slti.
- Stretches memory states until the memory handshake completes.
- Drives the same datapath select/enable signals as the existing controller.
- Generates alu_op directly; no separate ALU controller is instantiated.

Parameters:
- CNT_W, 32, width of cycle_cnt and instr_cnt.
- TIMEOUT, 15, maximum consecutive mem_ready=0 cycles tolerated in one memory state; 0 disables the timeout.
- HAS_JAL, 1, 1 enables the jal path; 0 treats opcode 000011 as illegal.

Ports:
- clk  input  1  system clock, rising edge.
- rst  input  1  asynchronous, active-low reset (0 = reset).
- zero  input  1  ALU zero flag.
- opcode  input  6  IR[31:26].
- func  input  6  IR[5:0].
- mem_ready  input  1  memory access completes this cycle.
- pc_write_en  output  1  final PC load enable (write OR conditional branch).
- ir_write  output  1  IR load enable.
- reg_dst, jal_reg, pc_to_reg, mem_to_reg, reg_write, alu_src_a, i_or_d, mem_write, mem_read  output  1 each  datapath controls.
- alu_src_b  output  2  ALU B select: 00 reg, 01 const 4, 10 sign-extended imm, 11 shifted imm.
- pc_src  output  2  PC source: 00 ALU, 01 jump target, 10 rs, 11 ALUOut.
- alu_op  output  3  ALU operation: 000 and, 001 or, 010 add, 110 sub, 111 slt.
- state  output  4  current state, for debug.
- illegal_op  output  1  sticky illegal-instruction flag.
- bus_err  output  1  sticky memory-timeout flag.
- cycle_cnt  output  CNT_W  clock cycles counted since reset.
- instr_cnt  output  CNT_W  instructions retired since reset.

Behaviour:
- State register:
  - 4-bit; async clear to IF when rst=0; otherwise updates on the clk rising edge.
  - Encodings: IF=0, ID=1, BRANCH=2, JUMP=3, RTYPE_EX=4, RTYPE_WB=5, MEM_ADDR=6, LW_READ=7, LW_WB=8, SW_WRITE=9, JAL=10, JR=11, IMM_EX=12, IMM_WB=13, ERR=15.
- Output decode: Moore decode of state, except ir_write and pc_write_en, which are Mealy on mem_ready and zero. Unlisted controls are 0; default alu_op is 010.
- IF:
  - mem_read=1, alu_src_b=01, alu_op=010.
  - ir_write = pc_write_en = mem_ready.
  - Advance to ID only when mem_ready=1; otherwise hold.
- ID:
  - alu_src_b=11, alu_op=010.
  - Next state by opcode:
    - 000100 or 000101 -> BRANCH.
    - 000010 -> JUMP.
    - 000011 -> JAL if HAS_JAL=1, else ERR.
    - 000000 with func 001000 -> JR.
    - 000000 with func in {add, sub, and, or, slt} -> RTYPE_EX.
    - 100011 or 101011 -> MEM_ADDR.
    - 001000, 001100 or 001010 -> IMM_EX.
    - Any other opcode or func -> ERR with illegal_op set.
- BRANCH:
  - alu_src_a=1, alu_op=110, pc_src=11.
  - pc_write_en = zero for beq, ~zero for bne.
  - Next state IF.
- JUMP: pc_src=01, pc_write_en=1, then IF.
- JAL: reg_dst=1, jal_reg=1, pc_to_reg=1, reg_write=1, pc_src=01, pc_write_en=1, then IF.
- JR: pc_src=10, pc_write_en=1, then IF.
- RTYPE_EX:
  - alu_src_a=1.
  - alu_op from func: 100000->010, 100010->110, 100100->000, 100101->001, 101010->111.
  - Next state RTYPE_WB.
- RTYPE_WB: reg_dst=1, reg_write=1, then IF.
- IMM_EX:
  - alu_src_a=1, alu_src_b=10.
  - alu_op: addi 010, andi 000, slti 111.
  - Next state IMM_WB.
- IMM_WB: reg_dst=0, reg_write=1, then IF.
- MEM_ADDR: alu_src_a=1, alu_src_b=10, alu_op=010; lw -> LW_READ, sw -> SW_WRITE.
- LW_READ: mem_read=1, i_or_d=1; hold until mem_ready=1, then LW_WB.
- LW_WB: mem_to_reg=1, reg_write=1, reg_dst=0, then IF.
- SW_WRITE: mem_write=1, i_or_d=1; hold until mem_ready=1, then IF.
- Wait counter:
  - Clears on entering any memory state (IF, LW_READ, SW_WRITE) and whenever mem_ready=1.
  - Increments each cycle mem_ready=0 while in a memory state.
  - When TIMEOUT≠0 and the counter equals TIMEOUT with mem_ready still 0, the next state is ERR and bus_err is set.
- ERR:
  - All enables 0, including mem_read, mem_write, reg_write, pc_write_en and ir_write.
  - Terminal state; exit only via rst.
  - illegal_op and bus_err stay set until rst.
- cycle_cnt: increments every cycle except in ERR; wraps modulo 2^CNT_W.
- instr_cnt: increments on every transition into IF from a non-IF, non-ERR state; wraps modulo 2^CNT_W.
- Reset values:
  - state=0; cycle_cnt=0; instr_cnt=0; illegal_op=0; bus_err=0; wait counter=0.
  - Controls take the IF decode: mem_read=1, alu_src_b=01, alu_op=010, ir_write = pc_write_en = mem_ready.
- Reset asserted mid-instruction or mid-wait: immediate return to IF. No partial write may be issued after rst falls.

Test Plan:
- add (opcode 0, func 100000) with mem_ready=1 always:
  - States visited IF->ID->RTYPE_EX->RTYPE_WB->IF; alu_op=010 in RTYPE_EX.
  - reg_write=1 only in RTYPE_WB; instr_cnt goes 0->1 after 4 cycles.
- lw with mem_ready low for 3 cycles in LW_READ:
  - LW_READ lasts 4 cycles; mem_read=1 and i_or_d=1 throughout.
  - LW_WB follows with mem_to_reg=1; instr_cnt +1.
- beq zero=1 and bne zero=1: pc_write_en=1 in BRANCH for beq and 0 for bne; pc_src=11 in both cases.
- jal with HAS_JAL=1: JAL state drives pc_to_reg=1, jal_reg=1, reg_write=1, pc_write_en=1. Same opcode with HAS_JAL=0: ERR and illegal_op=1.
- TIMEOUT=15 and mem_ready held at 0 in IF:
  - ERR entered after 16 cycles in IF; bus_err=1.
  - cycle_cnt freezes at 16; rst=0 clears the flags, counters and state.
- opcode 111111 -> ERR after ID with illegal_op=1. rst pulsed low mid-SW_WRITE -> state=0 immediately and mem_write=0.
